fifo_drain_ctrl: RTL

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_drain_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains a byte FIFO into a UART in bursts on threshold or idle timeout
module fifo_drain_ctrl #(
  parameter int THRESH  = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] fifo_cnt,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_dout,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       burst_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD, LATCH, START, WAIT_BSY, WAIT_DONE} state_t;
  state_t state, nxt;
  logic [TW-1:0] idle_tmr;
  logic [7:0] remain, prev_cnt;
  logic [3:0] wcnt;
  logic thr_hit, tmo_hit, trig, last;
  // out-of-range thresholds disable the level trigger, leaving only the timeout flush
  assign thr_hit = (THRESH > 0) && (THRESH <= 32) && (int'(fifo_cnt) >= THRESH);
  assign tmo_hit = (fifo_cnt != 8'd0) && (idle_tmr == TW'(TIMEOUT));
  assign trig    = en && (thr_hit || tmo_hit);
  assign last    = (remain <= 8'd1) || !en;
  always_ff @(posedge clk50M) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = trig ? RD : IDLE;
      RD:        nxt = fifo_empty ? IDLE : LATCH;
      LATCH:     nxt = START;
      START:     nxt = tx_busy ? START : WAIT_BSY;
      WAIT_BSY:  nxt = (tx_busy || wcnt == 4'd15) ? WAIT_DONE : WAIT_BSY;
      WAIT_DONE: nxt = tx_busy ? WAIT_DONE : (last ? IDLE : RD);
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    fifo_rd_en = !rst && state == RD && !fifo_empty;
    tx_start   = !rst && state == START && !tx_busy;
    burst_done = !rst && ((state == RD && fifo_empty) || (state == WAIT_DONE && !tx_busy && last));
    busy       = state != IDLE;
  end
  always_ff @(posedge clk50M) begin
    if (rst) begin
      idle_tmr <= '0;
      remain   <= 8'd0;
      prev_cnt <= 8'd0;
      wcnt     <= 4'd0;
      tx_data  <= 8'h00;
    end else begin
      prev_cnt <= fifo_cnt;
      wcnt     <= (state == WAIT_BSY) ? wcnt + 4'd1 : 4'd0;
      if (state == LATCH) tx_data <= fifo_dout;
      if (state != IDLE || trig || fifo_cnt == 8'd0 || fifo_cnt != prev_cnt) idle_tmr <= '0;
      else if (idle_tmr != TW'(TIMEOUT)) idle_tmr <= idle_tmr + 1'b1;
      if (state == IDLE && trig) remain <= fifo_cnt;
      else if (state == WAIT_DONE && !tx_busy && remain != 8'd0) remain <= remain - 8'd1;
    end
  end
endmodule
